sram_bus_ctrl: RTL
==================

SRAM_BUS_CTRL -- requirements
Module: sram_bus_ctrl

Interface
REQ-001 SHALL have parameter WORD_SIZE, default 8, data width.
REQ-002 SHALL have parameter ADDR_SIZE, default 11, address width ({row[6:0], col[3:0]}).
REQ-003 SHALL have parameters T_WSETUP=1, T_WPULSE=3, T_WHOLD=1, T_RACC=3, T_TURN=1, phase lengths in clk cycles, each >=1.
REQ-004 SHALL use one clock, clk; reset rst_b is asynchronous, active-low.
REQ-005 clk  input  1  clock, all state on rising edge.
REQ-006 rst_b  input  1  async active-low reset.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  request accepted when req_valid & req_ready at clk edge.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_SIZE  target address.
REQ-011 req_wdata  input  WORD_SIZE  write data.
REQ-012 rsp_valid  output  1  one-cycle pulse, read data valid.
REQ-013 rsp_rdata  output  WORD_SIZE  read data, held until next read completes.
REQ-014 verify_err  output  1  sticky write-verify mismatch flag.
REQ-015 addr  output  ADDR_SIZE  SRAM address.
REQ-016 CS_b, OE_b, WE_b  output  1 each  SRAM active-low controls.
REQ-017 data_bus  inout  WORD_SIZE  SRAM bidirectional bus.

Function
REQ-018 FSM states SHALL be IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACCESS, TURN, plus V_ACCESS when verify is compiled in.
REQ-019 req_ready SHALL be 1 only in IDLE; no request queuing; req_* latched on acceptance and ignored thereafter.
REQ-020 Write: W_SETUP (CS_b=0, WE_b=1, OE_b=1) T_WSETUP cycles -> W_PULSE (WE_b=0) T_WPULSE cycles -> W_HOLD (WE_b=1, CS_b=0) T_WHOLD cycles -> IDLE.
REQ-021 addr and data_bus SHALL be stable, driven with latched values, from first W_SETUP cycle through last W_HOLD cycle.
REQ-022 data_bus SHALL be driven only in W_SETUP/W_PULSE/W_HOLD with OE_b=1; Hi-Z in all other states.
REQ-023 Read: R_ACCESS (CS_b=0, OE_b=0, WE_b=1) T_RACC cycles; data_bus sampled on the last R_ACCESS edge into rsp_rdata; rsp_valid=1 the following cycle; then TURN.
REQ-024 TURN: CS_b=1, OE_b=1, bus Hi-Z for T_TURN cycles, then IDLE; prevents contention before a following write.
REQ-025 Outside active states CS_b=OE_b=WE_b=1; addr holds last value.
REQ-026 Write request latency: req_ready returns high exactly T_WSETUP+T_WPULSE+T_WHOLD cycles after acceptance edge (no verify).
REQ-027 Read latency: rsp_valid high T_RACC+1 cycles after acceptance edge; req_ready high T_RACC+T_TURN cycles after acceptance edge.
REQ-028 Phase counters SHALL use width clog2(max T_*)+1; no wrap for any legal parameter.

Reset
REQ-029 rst_b low SHALL immediately force CS_b=OE_b=WE_b=1, data_bus Hi-Z, rsp_valid=0, req_ready=0, verify_err=0, rsp_rdata=0, addr=0, FSM IDLE.
REQ-030 Reset mid-write (any write state) SHALL abort without further WE_b pulse; req_ready=1 first cycle after rst_b deasserts.

Configuration
REQ-031 Macro SRAM_BUS_CTRL_VERIFY_EN defined: after W_HOLD, enter V_ACCESS (read timing of REQ-023, no rsp_valid), compare to latched wdata, set verify_err on mismatch, then TURN, then IDLE.
REQ-032 Macro undefined: V_ACCESS absent, W_HOLD -> IDLE, verify_err tied 0.

Structure
REQ-033 Package sram_bus_pkg SHALL hold the state enum typedef and default timing constants.
REQ-034 Sub-module sram_phase_timer SHALL provide the loadable down-counter with done flag used by all phases.

Verification
REQ-035 Write 8'h01 to addr 11'h000 -> WE_b low exactly 3 cycles, data_bus=8'h01 from setup through hold, req_ready back after 5 cycles.
REQ-036 Read 11'h000 with SRAM model -> OE_b low 3 cycles, rsp_valid pulse at cycle 4, rsp_rdata=8'h01.
REQ-037 Walking ones: 16 cols x 128 rows, pattern 8'h01 rotated left per row -> all 2048 read-backs match, no X on data_bus.
REQ-038 Read then immediate write -> TURN cycle with bus Hi-Z between OE_b rising and first driven write data; no contention.
REQ-039 rst_b low during W_PULSE -> WE_b=1 same edge-independent instant, bus Hi-Z, req_ready=1 one cycle after release.
REQ-040 VERIFY_EN, model corrupts bit 3 on write of 8'h80 -> verify_err=1 and stays set until reset.

Source files
------------

// File: rtl/sram_bus_pkg.sv
// Shared types and default phase timing for the SRAM bus controller.
// The V_ACCESS state exists only when SRAM_BUS_CTRL_VERIFY_EN is defined.
package sram_bus_pkg;

  localparam int DEF_T_WSETUP = 1;
  localparam int DEF_T_WPULSE = 3;
  localparam int DEF_T_WHOLD  = 1;
  localparam int DEF_T_RACC   = 3;
  localparam int DEF_T_TURN   = 1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_W_SETUP  = 3'd1,
    ST_W_PULSE  = 3'd2,
    ST_W_HOLD   = 3'd3,
    ST_R_ACCESS = 3'd4,
    ST_TURN     = 3'd5
`ifdef SRAM_BUS_CTRL_VERIFY_EN
    , ST_V_ACCESS = 3'd6
`endif
  } state_t;

  typedef struct packed {
    logic cs_b;
    logic oe_b;
    logic we_b;
    logic drive;
  } pins_t;

  // SRAM pin levels and bus drive enable for the cycles spent in a state.
  function automatic pins_t pins_of(state_t s);
    pins_t p;
    p = '{cs_b: 1'b1, oe_b: 1'b1, we_b: 1'b1, drive: 1'b0};
    case (s)
      ST_W_SETUP:  p = '{cs_b: 1'b0, oe_b: 1'b1, we_b: 1'b1, drive: 1'b1};
      ST_W_PULSE:  p = '{cs_b: 1'b0, oe_b: 1'b1, we_b: 1'b0, drive: 1'b1};
      ST_W_HOLD:   p = '{cs_b: 1'b0, oe_b: 1'b1, we_b: 1'b1, drive: 1'b1};
      ST_R_ACCESS: p = '{cs_b: 1'b0, oe_b: 1'b0, we_b: 1'b1, drive: 1'b0};
`ifdef SRAM_BUS_CTRL_VERIFY_EN
      ST_V_ACCESS: p = '{cs_b: 1'b0, oe_b: 1'b0, we_b: 1'b1, drive: 1'b0};
`endif
      default:     p = '{cs_b: 1'b1, oe_b: 1'b1, we_b: 1'b1, drive: 1'b0};
    endcase
    return p;
  endfunction

  function automatic int max_of5(int a, int b, int c, int d, int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    if (e > m) m = e;
    return m;
  endfunction

endpackage

// File: rtl/sram_phase_timer.sv
// Loadable down-counter: a load of N makes done high in the Nth (last) cycle of the phase.
module sram_phase_timer #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  output logic          done
);

  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val - ONE;
    end else if (cnt != '0) begin
      cnt <= cnt - ONE;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/sram_bus_ctrl.sv
// Single-port asynchronous SRAM controller with timed write/read phases and bus turnaround.
// Define SRAM_BUS_CTRL_VERIFY_EN to add a read-back verify after every write.
module sram_bus_ctrl
  import sram_bus_pkg::*;
#(
  parameter int WORD_SIZE = 8,
  parameter int ADDR_SIZE = 11,
  parameter int T_WSETUP  = DEF_T_WSETUP,
  parameter int T_WPULSE  = DEF_T_WPULSE,
  parameter int T_WHOLD   = DEF_T_WHOLD,
  parameter int T_RACC    = DEF_T_RACC,
  parameter int T_TURN    = DEF_T_TURN
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [ADDR_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [WORD_SIZE-1:0] rsp_rdata,
  output logic                 verify_err,
  output logic [ADDR_SIZE-1:0] addr,
  output logic                 CS_b,
  output logic                 OE_b,
  output logic                 WE_b,
  inout  wire  [WORD_SIZE-1:0] data_bus,
  output logic [2:0]           dbg_state
);

  localparam int T_MAX = max_of5(T_WSETUP, T_WPULSE, T_WHOLD, T_RACC, T_TURN);
  localparam int CW    = $clog2(T_MAX) + 1;

  state_t               state;
  pins_t                pins;
  logic [WORD_SIZE-1:0] wdata_q;
  logic                 rsp_pend;
  logic                 done;
  logic                 load;
  logic [CW-1:0]        load_val;
`ifdef SRAM_BUS_CTRL_VERIFY_EN
  logic                 verify_q;
`endif

  // Timer reloads every idle cycle and at every phase end with the next phase's length.
  always_comb begin
    load     = done;
    load_val = CW'(T_TURN);
    case (state)
      ST_IDLE: begin
        load     = 1'b1;
        load_val = req_we ? CW'(T_WSETUP) : CW'(T_RACC);
      end
      ST_W_SETUP:  load_val = CW'(T_WPULSE);
      ST_W_PULSE:  load_val = CW'(T_WHOLD);
      ST_W_HOLD:   load_val = CW'(T_RACC);
      default:     load_val = CW'(T_TURN);
    endcase
  end

  sram_phase_timer #(.CW(CW)) u_timer (
    .clk      (clk),
    .rst_b    (rst_b),
    .load     (load),
    .load_val (load_val),
    .done     (done)
  );

  // Handshake: a request is taken on a clk edge where req_valid && req_ready; req_ready
  // is high only while idle, and req_* are ignored until the controller is idle again.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state     <= ST_IDLE;
      pins      <= pins_of(ST_IDLE);
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_pend  <= 1'b0;
      rsp_rdata <= '0;
      addr      <= '0;
      wdata_q   <= '0;
`ifdef SRAM_BUS_CTRL_VERIFY_EN
      verify_q  <= 1'b0;
`endif
    end else begin
      rsp_valid <= rsp_pend;
      rsp_pend  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid && req_ready) begin
            req_ready <= 1'b0;
            addr      <= req_addr;
            wdata_q   <= req_wdata;
            if (req_we) begin
              state <= ST_W_SETUP;
              pins  <= pins_of(ST_W_SETUP);
            end else begin
              state <= ST_R_ACCESS;
              pins  <= pins_of(ST_R_ACCESS);
            end
          end else begin
            req_ready <= 1'b1;
          end
        end
        ST_W_SETUP: if (done) begin
          state <= ST_W_PULSE;
          pins  <= pins_of(ST_W_PULSE);
        end
        ST_W_PULSE: if (done) begin
          state <= ST_W_HOLD;
          pins  <= pins_of(ST_W_HOLD);
        end
        ST_W_HOLD: if (done) begin
`ifdef SRAM_BUS_CTRL_VERIFY_EN
          state <= ST_V_ACCESS;
          pins  <= pins_of(ST_V_ACCESS);
`else
          state     <= ST_IDLE;
          pins      <= pins_of(ST_IDLE);
          req_ready <= 1'b1;
`endif
        end
        ST_R_ACCESS: if (done) begin
          rsp_rdata <= data_bus;
          rsp_pend  <= 1'b1;
          state     <= ST_TURN;
          pins      <= pins_of(ST_TURN);
        end
`ifdef SRAM_BUS_CTRL_VERIFY_EN
        ST_V_ACCESS: if (done) begin
          if (data_bus != wdata_q) verify_q <= 1'b1;
          state <= ST_TURN;
          pins  <= pins_of(ST_TURN);
        end
`endif
        ST_TURN: if (done) begin
          state     <= ST_IDLE;
          pins      <= pins_of(ST_IDLE);
          req_ready <= 1'b1;
        end
        default: begin
          state <= ST_IDLE;
          pins  <= pins_of(ST_IDLE);
        end
      endcase
    end
  end

  assign CS_b      = pins.cs_b;
  assign OE_b      = pins.oe_b;
  assign WE_b      = pins.we_b;
  assign data_bus  = pins.drive ? wdata_q : 'z;
  assign dbg_state = state;

`ifdef SRAM_BUS_CTRL_VERIFY_EN
  assign verify_err = verify_q;
`else
  assign verify_err = 1'b0;
`endif

endmodule
